// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debounce timer bank: the per-channel FSM state
// encoding and the default counter width / default threshold constants.
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int CNT_W_DEFAULT      = 16;
  localparam int DEF_THRESH_DEFAULT = 50;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounce timer. Counts consecutive enable-high edges and pulses `delay`
// for one cycle when the count reaches the threshold latched at arm time.
// One-shot mode parks in HELD with `expired` high; periodic mode re-arms.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   enable     "input stable" qualifier; low returns the channel to IDLE
//   threshold  runtime threshold, 0 selects DEF_THRESH; latched on arm
//   periodic   0 = one-shot, 1 = periodic re-arm
//   delay      registered one-cycle pulse on reaching the latched threshold
//   expired    registered level, high while parked in HELD
//   counting   next-state-is-COUNT, registered and ORed by the bank into busy
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int DEF_THRESH = DEF_THRESH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] threshold,
  input  logic             periodic,
  output logic             delay,
  output logic             expired,
  output logic             counting
);

  localparam logic [CNT_W-1:0] DEF_T = CNT_W'(DEF_THRESH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] tl_q, tl_d;
  logic             delay_d, expired_d;

  logic [CNT_W-1:0] thr_sel;
  logic [CNT_W-1:0] count_inc;
  logic             reach;

  assign thr_sel   = (threshold == '0) ? DEF_T : threshold;
  // count stays strictly below tl_q while in COUNT, so this cannot wrap.
  assign count_inc = count_q + ONE;

  // NOTE: every variable gets a default before the case so no path through
  // this block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tl_d      = tl_q;
    delay_d   = 1'b0;
    expired_d = expired_q_w();
    reach     = 1'b0;

    if (!enable) begin
      // Enable low beats everything, including a coincident reach edge.
      state_d   = ST_IDLE;
      count_d   = '0;
      expired_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tl_d = thr_sel;
          if (thr_sel == ONE) begin
            reach = 1'b1;
          end else begin
            state_d = ST_COUNT;
            count_d = ONE;
          end
        end
        ST_COUNT: begin
          if (count_inc == tl_q) reach   = 1'b1;
          else                   count_d = count_inc;
        end
        ST_HELD: begin
          if (periodic) begin
            state_d   = ST_COUNT;
            count_d   = '0;
            expired_d = 1'b0;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          count_d   = '0;
          expired_d = 1'b0;
        end
      endcase

      // Reach action uses the threshold latched on this edge (tl_d), which
      // also covers the T=1 case taken directly from IDLE.
      if (reach) begin
        delay_d = 1'b1;
        if (periodic) begin
          state_d = ST_COUNT;
          count_d = '0;
        end else begin
          state_d   = ST_HELD;
          count_d   = tl_d;
          expired_d = 1'b1;
        end
      end
    end
  end

  function automatic logic expired_q_w();
    return expired;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tl_q    <= DEF_T;
      delay   <= 1'b0;
      expired <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tl_q    <= tl_d;
      delay   <= delay_d;
      expired <= expired_d;
    end
  end

  assign counting = (state_d == ST_COUNT);

endmodule

// File: rtl/debounce_timer_bank.sv
// -----------------------------------------------------------------------------
// debounce_timer_bank
// CHANNELS independent debounce timers sharing one threshold and mode input.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   enable     per-channel "input stable" qualifier
//   threshold  shared runtime threshold in cycles, 0 selects DEF_THRESH
//   periodic   0 = one-shot, 1 = periodic re-arm
//   delay      per-channel one-cycle pulse on reaching the threshold
//   expired    per-channel level while a one-shot channel holds
//   busy       registered OR of channels currently in COUNT
// -----------------------------------------------------------------------------
module debounce_timer_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int DEF_THRESH = DEF_THRESH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CNT_W-1:0]    threshold,
  input  logic                periodic,
  output logic [CHANNELS-1:0] delay,
  output logic [CHANNELS-1:0] expired,
  output logic                busy
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("debounce_timer_bank: CHANNELS must be 1..32");
  end
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("debounce_timer_bank: CNT_W must be 1..31");
  end
  if (DEF_THRESH < 1 || DEF_THRESH > (2 ** CNT_W) - 1) begin : g_bad_thresh
    $error("debounce_timer_bank: DEF_THRESH must be 1..2^CNT_W-1");
  end

  logic [CHANNELS-1:0] counting;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .DEF_THRESH (DEF_THRESH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable[i]),
      .threshold (threshold),
      .periodic  (periodic),
      .delay     (delay[i]),
      .expired   (expired[i]),
      .counting  (counting[i])
    );
  end

  // Registered from each channel's next state, so busy lines up with the
  // channel states held in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= 1'b0;
    else      busy <= |counting;
  end

endmodule

// File: tb/tb_debounce_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_timer_bank
// Directed stimulus against a behavioural model of the bank: the model tracks
// edges since arming per channel and applies the reach / hold / re-arm rules.
// Outputs are compared with the model on every falling edge; directed tests
// additionally pin the edge numbers at which pulses appear.
// -----------------------------------------------------------------------------
module tb_debounce_timer_bank;

  localparam int CH  = 4;
  localparam int CW  = 16;
  localparam int DEF = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] enable;
  logic [CW-1:0] threshold;
  logic          periodic;
  logic [CH-1:0] delay;
  logic [CH-1:0] expired;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_timer_bank #(
    .CHANNELS   (CH),
    .CNT_W      (CW),
    .DEF_THRESH (DEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .threshold (threshold),
    .periodic  (periodic),
    .delay     (delay),
    .expired   (expired),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int run  [CH];   // consecutive enable-high edges
  int pos  [CH];   // edges since the channel was last armed
  int tl   [CH];   // threshold latched at arm time
  bit held [CH];
  bit m_dly[CH];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        run[c] = 0; pos[c] = 0; tl[c] = DEF; held[c] = 0; m_dly[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_dly[c] = 0;
        if (!enable[c]) begin
          run[c] = 0; pos[c] = 0; held[c] = 0;
        end else begin
          if (run[c] == 0) tl[c] = (threshold == 0) ? DEF : int'(threshold);
          run[c]++;
          if (held[c]) begin
            if (periodic) begin held[c] = 0; pos[c] = 0; end
          end else begin
            pos[c]++;
            if (pos[c] == tl[c]) begin
              m_dly[c] = 1;
              if (periodic) pos[c] = 0;
              else          held[c] = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      bit m_busy;
      m_busy = 0;
      for (int c = 0; c < CH; c++) begin
        check($sformatf("delay[%0d]", c),   64'(delay[c]),   64'(m_dly[c]));
        check($sformatf("expired[%0d]", c), 64'(expired[c]), 64'(held[c]));
        if (run[c] > 0 && !held[c]) m_busy = 1;
      end
      check("busy", 64'(busy), 64'(m_busy));
    end
  end

  // ---------------- pulse recorder ----------------
  int edge_cnt = 0;
  int pulses[CH][$];

  always @(posedge clk) edge_cnt++;
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++)
      if (delay[c] === 1'b1) pulses[c].push_back(edge_cnt);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Compare the pulses of channel c after edge `base` with a literal list.
  task automatic check_pulses(input string name, input int c, input int base,
                              input int exp[$]);
    int got[$];
    foreach (pulses[c][i]) if (pulses[c][i] > base) got.push_back(pulses[c][i] - base);
    check({name, " count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s pulse%0d edge", name, i), 64'(got[i]), 64'(exp[i]));
  endtask

  initial begin
    int base;
    rst = 1'b0; enable = '0; threshold = CW'(DEF); periodic = 1'b0;
    #1;
    check("reset delay",   64'(delay),   64'(0));
    check("reset expired", 64'(expired), 64'(0));
    check("reset busy",    64'(busy),    64'(0));
    step(2);
    rst = 1'b1;
    step(2);

    // One-shot T=50 on channel 0, enable high for 60 edges.
    base = edge_cnt; threshold = 16'd50; enable[0] = 1'b1;
    step(20);
    check("oneshot busy mid", 64'(busy), 64'(1));
    step(40);
    check("oneshot expired held", 64'(expired[0]), 64'(1));
    check("oneshot busy held",    64'(busy),       64'(0));
    enable[0] = 1'b0;
    step(1);
    check("oneshot expired cleared", 64'(expired[0]), 64'(0));
    step(1);
    check_pulses("oneshot", 0, base, '{50});

    // Bounce: 30 high, 1 low, 50 high on channel 1.
    base = edge_cnt; enable[1] = 1'b1;
    step(30); enable[1] = 1'b0;
    step(1);  enable[1] = 1'b1;
    step(50); enable[1] = 1'b0;
    step(2);
    check_pulses("bounce", 1, base, '{81});

    // Periodic T=3 on channel 2 for 10 edges.
    base = edge_cnt; threshold = 16'd3; periodic = 1'b1; enable[2] = 1'b1;
    step(10); enable[2] = 1'b0;
    step(2);  periodic = 1'b0;
    check_pulses("periodic", 2, base, '{3, 6, 9});

    // threshold=0 selects DEF_THRESH.
    base = edge_cnt; threshold = '0; enable[0] = 1'b1;
    step(52); enable[0] = 1'b0;
    step(2);
    check_pulses("default thresh", 0, base, '{50});

    // Threshold change after arming is ignored.
    base = edge_cnt; threshold = 16'd5; enable[1] = 1'b1;
    step(2);  threshold = 16'd100;
    step(5);  enable[1] = 1'b0;
    step(2);
    check_pulses("latched thresh", 1, base, '{5});

    // Async reset at count 40 of 50, then restart.
    threshold = 16'd50; enable[0] = 1'b1;
    step(40);
    rst = 1'b0;
    #1;
    check("async rst delay",   64'(delay),   64'(0));
    check("async rst expired", 64'(expired), 64'(0));
    check("async rst busy",    64'(busy),    64'(0));
    step(1);
    rst = 1'b1; base = edge_cnt;
    step(55); enable[0] = 1'b0;
    step(2);
    check_pulses("restart", 0, base, '{50});

    // Coincidence T=4: channel 0 drops on its reach edge, channel 3 reaches.
    base = edge_cnt; threshold = 16'd4; enable = 4'b1001;
    step(3); enable[0] = 1'b0;
    step(3); enable = '0;
    step(2);
    check_pulses("coincide ch0", 0, base, '{});
    check_pulses("coincide ch3", 3, base, '{4});

    // HELD with periodic raised re-arms from zero.
    base = edge_cnt; threshold = 16'd2; enable[1] = 1'b1;
    step(4); periodic = 1'b1;
    step(5); enable[1] = 1'b0; periodic = 1'b0;
    step(2);
    check_pulses("held rearm", 1, base, '{2, 7, 9});

    // T=1 one-shot, then T=1 periodic.
    base = edge_cnt; threshold = 16'd1; enable[2] = 1'b1;
    step(3); enable[2] = 1'b0;
    step(1);
    check_pulses("t1 oneshot", 2, base, '{1});
    base = edge_cnt; periodic = 1'b1; enable[3] = 1'b1;
    step(3); enable[3] = 1'b0;
    step(1); periodic = 1'b0;
    check_pulses("t1 periodic", 3, base, '{1, 2, 3});

    // periodic dropped mid-count applies at the next reach.
    base = edge_cnt; threshold = 16'd3; periodic = 1'b1; enable[0] = 1'b1;
    step(2); periodic = 1'b0;
    step(4); enable[0] = 1'b0;
    step(2);
    check_pulses("periodic to oneshot", 0, base, '{3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
